skew_ifmap_buffer: RTL
======================

Name: skew_ifmap_buffer

Overview:
- Parametrised successor of the per-column ifmap delay buffer that feeds the PE array's vertical inputs.
- Holds COL_NUM independent DATA_W-bit shift chains with configurable delay.
- Runtime mode: uniform delay, or systolic skew where column c is delayed c extra cycles.
- Adds stall/hold, synchronous flush, per-column valid tracking, and an IDLE/FILL/STREAM/DRAIN status FSM so the controller knows when a layer has fully drained.

Parameters:
- COL_NUM, 32, number of columns (PE array width)
- DATA_W, 8, bits per ifmap element
- BASE_DEPTH, 4, delay in cycles of every column in uniform mode and of column 0 in skew mode; must be >= 1

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- ifmap_in  input  COL_NUM*DATA_W  column c occupies bits [c*DATA_W +: DATA_W]
- ifmap_en  input  1  ifmap_in valid this cycle
- stall  input  1  freeze all stages
- flush  input  1  synchronous clear of all stages
- skew_mode  input  1  0 = uniform, 1 = skewed; sampled only in IDLE
- ifmap_out  output  COL_NUM*DATA_W  delayed data per column
- out_valid  output  COL_NUM  per-column valid of ifmap_out
- busy  output  1  FSM not in IDLE
- drain_done  output  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Delay definitions:
  - D_MAX = BASE_DEPTH + COL_NUM - 1.
  - Column delay D_c = BASE_DEPTH in uniform mode, BASE_DEPTH + c in skew mode.
  - D_top = BASE_DEPTH in uniform mode, D_MAX in skew mode.
- Storage: per column, a data chain plus a 1-bit valid chain of length D_MAX. ifmap_out/out_valid for column c are taken from stage D_c-1 of the latched mode.
- Reset (reset=0, async): all data and valid stages 0, ifmap_out=0, out_valid=0, busy=0, drain_done=0, mode_r=0, FSM=IDLE, counters 0.
- Advance cycle = rising edge with stall=0 and flush=0. On each advance cycle:
  - stage0 <= ifmap_en ? ifmap_in : 0, and its valid bit <= ifmap_en.
  - Every stage i takes stage i-1.
- Latency: data presented in cycle k with ifmap_en=1 appears on column c in cycle k+D_c, with out_valid[c]=1, when no stall occurs in between. Each stall cycle adds exactly one cycle.
- stall=1: no stage shifts, ifmap_in is ignored, outputs hold, FSM and counters hold.
- flush=1: all stages and valids cleared to 0, FSM goes to IDLE, counters cleared, no drain_done pulse. flush has priority over stall and ifmap_en.
- mode_r <= skew_mode on any non-stalled cycle while FSM=IDLE. skew_mode is ignored in all other states.
- FSM (evaluated on advance cycles only), with cnt counting up to D_top:
  - IDLE: ifmap_en=1 -> FILL, cnt=1.
  - FILL: ifmap_en=1 -> cnt++; when cnt reaches D_top -> STREAM. ifmap_en=0 -> DRAIN, cnt=1.
  - STREAM: ifmap_en=0 -> DRAIN, cnt=1.
  - DRAIN: ifmap_en=1 -> FILL, cnt=1. Otherwise cnt++; when cnt reaches D_top -> IDLE with drain_done=1 for that cycle.
- Exit condition: all valid stages are 0 when the FSM leaves DRAIN. The verifier checks this with an assertion.
- busy = (FSM != IDLE); it is registered in the same edge as the state.
- Reset asserted mid-stream: immediate clear, no drain_done.

Optional Feature:
- Macro: SKEW_IFMAP_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0] and input perf_clr.
  - perf_stall_cnt increments on every cycle with stall=1 and busy=1, and saturates at 0xFFFFFFFF.
  - perf_clr=1 zeroes it synchronously and has priority over the increment. Reset clears it to 0.
- Not defined: neither port nor the counter exists; all other behaviour is identical.

Test Plan:
- Uniform mode, BASE_DEPTH=4: ifmap_en=1 for one cycle with all columns 0xA5 at cycle 0 -> every column shows 0xA5 and out_valid=all-ones in cycle 4 only; zero elsewhere. drain_done pulses at cycle 5.
- Skew mode, COL_NUM=32: single beat with column c = c at cycle 0 -> column c outputs value c, valid, in cycle 4+c. busy stays 1 until cycle 36; drain_done in that cycle.
- Continuous stream of 40 beats, uniform mode, 3-cycle stall at beat 10 -> the output sequence is unchanged and shifted by 3 cycles; no beat is lost or duplicated; FSM passes FILL->STREAM after 4 beats.
- flush asserted together with stall while in STREAM -> the next cycle has all out_valid=0, ifmap_out=0, busy=0, and no drain_done.
- skew_mode toggled 0->1 during STREAM -> delays stay uniform until after IDLE; the next layer is skewed.
- Macro defined: 7 stall cycles while busy, then perf_clr -> perf_stall_cnt reads 7, then 0. Stalls while idle are not counted.

Source files
------------

// File: rtl/skew_ifmap_buffer.sv
// Per-column ifmap delay chains (uniform or systolic-skew delay) with stall, flush and a drain status FSM.
// Build option: define SKEW_IFMAP_PERF_EN to add the perf_stall_cnt counter and its perf_clr input.
//
// state  | meaning
// IDLE   | nothing in flight; delay mode latched from skew_mode
// FILL   | beats entering, fewer than D_top beats accepted so far
// STREAM | chains full, steady-state streaming
// DRAIN  | input stopped, remaining beats leaving the chains

module skew_ifmap_buffer #(
    parameter int COL_NUM    = 32,
    parameter int DATA_W     = 8,
    parameter int BASE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COL_NUM*DATA_W-1:0] ifmap_in,
    input  logic                      ifmap_en,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      skew_mode,
`ifdef SKEW_IFMAP_PERF_EN
    input  logic                      perf_clr,
    output logic [31:0]               perf_stall_cnt,
`endif
    output logic [COL_NUM*DATA_W-1:0] ifmap_out,
    output logic [COL_NUM-1:0]        out_valid,
    output logic                      busy,
    output logic                      drain_done
);

    localparam int D_MAX = BASE_DEPTH + COL_NUM - 1;
    localparam int CNT_W = $clog2(D_MAX + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, d_top;
    logic             mode_q, busy_q, done_q, done_d;

    assign d_top   = mode_q ? CNT_W'(D_MAX) : CNT_W'(BASE_DEPTH);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ifmap_en) begin
                    state_d = FILL;
                    cnt_d   = CNT_W'(1);
                end
            end
            FILL: begin
                if (!ifmap_en) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_inc >= d_top) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STREAM: begin
                if (!ifmap_en) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(1);
                end
            end
            DRAIN: begin
                if (ifmap_en) begin
                    state_d = FILL;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_inc >= d_top) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            if (state_q == IDLE) begin
                mode_q <= skew_mode;
            end
        end else begin
            // keep drain_done a single-cycle pulse even if a stall lands on it
            done_q <= 1'b0;
        end
    end

    assign busy       = busy_q;
    assign drain_done = done_q;

    for (genvar c = 0; c < COL_NUM; c++) begin : g_col
        localparam int DS = BASE_DEPTH + c;

        logic [DATA_W-1:0] data_q [D_MAX];
        logic [D_MAX-1:0]  vld_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < D_MAX; i++) data_q[i] <= '0;
                vld_q <= '0;
            end else if (flush) begin
                for (int i = 0; i < D_MAX; i++) data_q[i] <= '0;
                vld_q <= '0;
            end else if (!stall) begin
                data_q[0] <= ifmap_en ? ifmap_in[c*DATA_W +: DATA_W] : '0;
                vld_q[0]  <= ifmap_en;
                for (int i = 1; i < D_MAX; i++) begin
                    // stages beyond this column's tap stay empty, so nothing stale outlives a drain
                    if (i < (mode_q ? DS : BASE_DEPTH)) begin
                        data_q[i] <= data_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                    end else begin
                        data_q[i] <= '0;
                        vld_q[i]  <= 1'b0;
                    end
                end
            end
        end

        assign ifmap_out[c*DATA_W +: DATA_W] = mode_q ? data_q[DS-1] : data_q[BASE_DEPTH-1];
        assign out_valid[c]                  = mode_q ? vld_q[DS-1]  : vld_q[BASE_DEPTH-1];
    end

`ifdef SKEW_IFMAP_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt <= '0;
        end else if (stall && busy_q && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
